// File: rtl/uart_cfg_pkg.sv
// Shared types for the UART line-configuration sequencer: FSM states, the
// tuner configuration record and the stop-bit legality check.
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_HOLD,
        ST_APPLY,
        ST_SETTLE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] br;
        logic [1:0]  sbl;
        logic        parity_on;
        logic        seniority_h;
        logic        parity_set;
    } uart_cfg_t;

    localparam uart_cfg_t UART_CFG_DEFAULT = '{
        br:          32'd115_200,
        sbl:         2'd1,
        parity_on:   1'b0,
        seniority_h: 1'b0,
        parity_set:  1'b0
    };

    function automatic logic sbl_legal(input logic [1:0] sbl);
        return (sbl == 2'd1) || (sbl == 2'd2);
    endfunction

endpackage

// File: rtl/uart_quiet_detector.sv
// Counts consecutive idle cycles and total cycles while enabled; flags the
// cycle on which either count reaches its limit.
module uart_quiet_detector
#(
    parameter int unsigned QUIET_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    input  logic idle,
    output logic quiet,
    output logic timeout
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

    logic [QW-1:0] quiet_cnt_q;
    logic [DW-1:0] drain_cnt_q;

    // Both flags look one step ahead so the FSM can leave on the reaching cycle.
    assign quiet   = en && idle && (quiet_cnt_q == QW'(QUIET_CYCLES - 1));
    assign timeout = en && (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            quiet_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else if (!en) begin
            quiet_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            quiet_cnt_q <= idle ? quiet_cnt_q + 1'b1 : '0;
            drain_cnt_q <= drain_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// Guards run-time reconfiguration of the UART tuner: validates a request,
// holds off TX, waits for a quiet line, then drives the bus and set strobe.
module uart_cfg_sequencer
    import uart_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned DEFAULT_BR    = 115_200,
    parameter int unsigned QUIET_CYCLES  = 2,
    parameter int unsigned SET_PULSE_LEN = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_br,
    input  logic [1:0]  req_sbl,
    input  logic        req_parity_on,
    input  logic        req_seniority_h,
    input  logic        req_parity_set,
    input  logic        tx_ready,
    input  logic        rx_ready,
    output logic        tx_hold,
    output logic [31:0] cfg_br,
    output logic [1:0]  cfg_sbl,
    output logic        cfg_parity_on,
    output logic        cfg_seniority_h,
    output logic        cfg_parity_set,
    output logic        set_l,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic        timeout_err
);

    if (QUIET_CYCLES < 1 || SET_PULSE_LEN < 1 || DRAIN_TIMEOUT <= QUIET_CYCLES
        || CLK_FREQ == 0) begin : g_bad_params
        $error("uart_cfg_sequencer: illegal parameter combination");
    end

    localparam int PW = (SET_PULSE_LEN > 1) ? $clog2(SET_PULSE_LEN) : 1;

    localparam uart_cfg_t BOOT_CFG = '{
        br:          32'(DEFAULT_BR),
        sbl:         UART_CFG_DEFAULT.sbl,
        parity_on:   UART_CFG_DEFAULT.parity_on,
        seniority_h: UART_CFG_DEFAULT.seniority_h,
        parity_set:  UART_CFG_DEFAULT.parity_set
    };

    state_e    state_q, state_d;
    uart_cfg_t shadow_q, shadow_d;
    uart_cfg_t cfg_q, cfg_d;
    uart_cfg_t req_cfg;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic boot_q, boot_d;
    logic set_l_q, tx_hold_q, req_ready_q, busy_q, done_q, cfg_err_q, timeout_err_q;
    logic set_l_d, tx_hold_d, req_ready_d, busy_d, done_d, cfg_err_d, timeout_err_d;
    logic hold_en, quiet, drain_timeout, accept;

    assign req_cfg = '{br: req_br, sbl: req_sbl, parity_on: req_parity_on,
                       seniority_h: req_seniority_h, parity_set: req_parity_set};
    assign hold_en = (state_q == ST_HOLD);
    assign accept  = req_valid && req_ready_q;

    uart_quiet_detector #(
        .QUIET_CYCLES (QUIET_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_quiet (
        .clk    (clk),
        .rst_l  (rst_l),
        .en     (hold_en),
        .idle   (tx_ready && rx_ready),
        .quiet  (quiet),
        .timeout(drain_timeout)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        cfg_d         = cfg_q;
        pulse_cnt_d   = '0;
        boot_d        = boot_q;
        cfg_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_APPLY;
            ST_IDLE: begin
                if (accept) begin
                    shadow_d = req_cfg;
                    if (req_br == 32'd0 || !sbl_legal(req_sbl)) cfg_err_d = 1'b1;
                    else                                         state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A quiet window completing on the timeout cycle still applies.
                if (quiet) begin
                    state_d = ST_APPLY;
                end else if (drain_timeout) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            ST_APPLY: begin
                if (pulse_cnt_q == PW'(SET_PULSE_LEN - 1)) state_d     = ST_SETTLE;
                else                                       pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
            ST_SETTLE: begin
                state_d = boot_q ? ST_IDLE : ST_DONE;
                boot_d  = 1'b0;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_BOOT;
        endcase

        if (state_d == ST_APPLY && state_q != ST_APPLY) cfg_d = boot_q ? BOOT_CFG : shadow_q;

        // Outputs are registered from the next state so they line up with it.
        set_l_d     = (state_d != ST_APPLY);
        tx_hold_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_BOOT;
            boot_q        <= 1'b1;
            pulse_cnt_q   <= '0;
            shadow_q      <= BOOT_CFG;
            cfg_q         <= BOOT_CFG;
            set_l_q       <= 1'b1;
            tx_hold_q     <= 1'b1;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_q        <= boot_d;
            pulse_cnt_q   <= pulse_cnt_d;
            shadow_q      <= shadow_d;
            cfg_q         <= cfg_d;
            set_l_q       <= set_l_d;
            tx_hold_q     <= tx_hold_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign tx_hold         = tx_hold_q;
    assign set_l           = set_l_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;
    assign timeout_err     = timeout_err_q;
    assign cfg_br          = cfg_q.br;
    assign cfg_sbl         = cfg_q.sbl;
    assign cfg_parity_on   = cfg_q.parity_on;
    assign cfg_seniority_h = cfg_q.seniority_h;
    assign cfg_parity_set  = cfg_q.parity_set;

endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

Controller that sequences run-time reconfiguration of the UART tuner. It accepts a new line configuration (baud rate, stop bits, parity), validates it, and stalls new TX frames. It waits until both TX and RX report idle for a programmable quiet window, then drives the tuner configuration bus and the active-low set strobe. It sits between the system register/CPU side and the tuner input of the UART top, and replaces direct, unguarded driving of `set_l`.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz (passed through for consistency; no internal use beyond documentation)
- `DEFAULT_BR`, 115_200, baud rate applied at boot
- `QUIET_CYCLES`, 2, consecutive idle cycles (tx_ready && rx_ready) required before applying; ≥1
- `SET_PULSE_LEN`, 2, cycles `set_l` is held low; ≥1
- `DRAIN_TIMEOUT`, 1_000_000, maximum HOLD cycles before abort; > QUIET_CYCLES

Ports:
- `clk` in 1: single clock; all logic rising-edge
- `rst_l` in 1: asynchronous, active-low reset
- `req_valid` in 1: configuration request valid
- `req_ready` out 1: high only in IDLE
- `req_br` in 32: requested baud rate
- `req_sbl` in 2: requested stop bits, legal values 1, 2
- `req_parity_on`, `req_seniority_h`, `req_parity_set` in 1 each: parity enable, MSB-first, parity type
- `tx_ready`, `rx_ready` in 1 each: UART TX/RX idle
- `tx_hold` out 1: upstream must not raise TX valid while high
- `cfg_br` out 32, `cfg_sbl` out 2, `cfg_parity_on`, `cfg_seniority_h`, `cfg_parity_set` out 1 each: registered tuner bus
- `set_l` out 1: active-low tuner set strobe
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse, request applied
- `cfg_err` out 1: one-cycle pulse, request rejected
- `timeout_err` out 1: one-cycle pulse, drain aborted

## Operation
- Reset values: `cfg_br`=DEFAULT_BR, `cfg_sbl`=1, parity flags 0, `set_l`=1, `tx_hold`=1, `req_ready`=0, `busy`=1, pulses 0; state BOOT.
- States: BOOT → APPLY → SETTLE → IDLE (boot path, no `done`). Request path: IDLE → HOLD → APPLY → SETTLE → DONE → IDLE.
- Accept is `req_valid && req_ready`. The request is captured into shadow registers. Validation happens on the accept cycle: `req_br`==0 or `req_sbl`∈{0,3} → `cfg_err` pulses next cycle, state stays IDLE, and cfg outputs are unchanged.
- HOLD: `tx_hold`=1. `quiet_cnt` increments on each cycle with tx_ready && rx_ready and clears to 0 otherwise. The state leaves HOLD on the cycle where the qualifying count reaches QUIET_CYCLES. `drain_cnt` counts every HOLD cycle. When it reaches DRAIN_TIMEOUT without quiet completion, the next state is IDLE, `timeout_err` pulses, the shadow is discarded, and cfg is unchanged. If quiet completes and timeout occurs on the same cycle, quiet wins.
- APPLY: cfg outputs load from the shadow (or defaults in boot) on the first APPLY cycle. `set_l`=0 for exactly SET_PULSE_LEN cycles.
- SETTLE: one cycle, `set_l`=1, `tx_hold`=1.
- DONE: `done`=1, `tx_hold`=0, `req_ready`=0. Next cycle is IDLE.
- IDLE: `tx_hold`=0, `req_ready`=1, `busy`=0. `req_valid` is ignored in all other states.
- `rst_l` low mid-operation: all outputs go to reset values immediately, the shadow is lost, and the boot apply is re-run after release.

## Timing
- Request accepted at cycle T with continuous idle: HOLD occupies T+1 to T+QUIET_CYCLES. APPLY follows for SET_PULSE_LEN cycles, then SETTLE, then DONE.
- Defaults give: HOLD T+1..T+2, APPLY T+3..T+4, SETTLE T+5, `done` at T+6, `req_ready` at T+7. Accept-to-done latency is QUIET_CYCLES+SET_PULSE_LEN+2.
- `tx_hold` rises at T+1 (registered). Upstream must tolerate one in-flight frame accepted at T; HOLD absorbs it.
- Boot: the first cycle after release is BOOT, then APPLY. `req_ready` first goes high at cycle SET_PULSE_LEN+3.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package `uart_cfg_pkg`: state enum, `uart_cfg_t` struct (br, sbl, parity_on, seniority_h, parity_set), `UART_CFG_DEFAULT` constant, and the sbl legality function.
- Sub-module `uart_quiet_detector`: the quiet counter plus drain timeout counter, with inputs `clk`, `rst_l`, `en`, `idle` and outputs `quiet`, `timeout`.

## Test plan
- Reset release, no request → `set_l` low cycles 2–3, `cfg_br`=115200, `cfg_sbl`=1, `req_ready`=1 at cycle 5, no `done`.
- Request br=9600, sbl=2, parity_on=1, both ready held high → `done` at T+6, `cfg_br`=9600 from T+3, `set_l` low T+3..T+4.
- Request with `rx_ready` low for 10 cycles after accept, and toggling once → APPLY starts only after 2 consecutive idle cycles. `tx_hold` stays high throughout.
- Request br=0, then a separate request with sbl=3 → `cfg_err` pulse each, cfg unchanged, `req_ready` continuously 1.
- DRAIN_TIMEOUT=20, `tx_ready` held low → `timeout_err` at T+21, `tx_hold` 0 after, cfg unchanged.
- `rst_l` asserted during APPLY → `set_l`=1 and `cfg_br`=DEFAULT_BR immediately, then a full boot apply sequence.
